// File: rtl/per_pkg.sv
// Shared definitions for the mask-driven bit permutation blocks.
package per_pkg;

   localparam int PER_WIDTH = 32;

   // Control states of the iterative permutation engines.
   typedef enum logic [1:0] {
      PER_IDLE = 2'd0,
      PER_RUN  = 2'd1,
      PER_DONE = 2'd2
   } per_state_t;

   // Six bits so that the low pointer can step to 32 and the high pointer
   // can step below 0 after the last bit of its group without aliasing
   // into a live index.
   typedef logic [5:0] per_ptr_t;

endpackage

// File: rtl/unper_step.sv
// Combinational lane group of the inverse permutation: resolves LANES
// consecutive result indices i, i-1, ..., i-LANES+1, chaining the j/k
// pointers from one lane to the next.
module unper_step
   import per_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic [PER_WIDTH-1:0] p,
   input  logic [PER_WIDTH-1:0] y,
   input  logic [4:0]           i_idx,
   input  per_ptr_t             j_ptr,
   input  per_ptr_t             k_ptr,
   output logic [LANES-1:0]     bits,
   output per_ptr_t             j_next,
   output per_ptr_t             k_next,
   output logic [5:0]           ones
);

   per_ptr_t   j_t;
   per_ptr_t   k_t;
   logic [4:0] m;

   // Walk the lanes MSB first; bits[LANES-1] belongs to index i_idx.
   always_comb begin
      j_t  = j_ptr;
      k_t  = k_ptr;
      ones = 6'd0;
      bits = '0;
      m    = i_idx;
      for (int l = 0; l < LANES; l++) begin
         m = i_idx - 5'(l);
         if (y[m]) begin
            bits[LANES-1-l] = p[j_t[4:0]];
            j_t             = j_t - 6'd1;
            ones            = ones + 6'd1;
         end else begin
            bits[LANES-1-l] = p[k_t[4:0]];
            k_t             = k_t + 6'd1;
         end
      end
      j_next = j_t;
      k_next = k_t;
   end

endmodule

// File: rtl/unper_32b.sv
// Inverse of the 32-bit mask-driven bit permutation. Accepts a permuted
// word P and its mask Y, then recovers X over WIDTH/LANES RUN cycles.
// Optional build macro UNPER_SCRUB_EN: clears X, ones_cnt and the latched
// P/Y copies on the output handshake edge.
module unper_32b
   import per_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] P,
   input  logic [WIDTH-1:0] Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] X,
   output logic [5:0]       ones_cnt
);

   per_state_t       state_q, state_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [4:0]       i_q, i_d;
   per_ptr_t         j_q, j_d;
   per_ptr_t         k_q, k_d;
   logic [WIDTH-1:0] xacc_q, xacc_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [5:0]       ones_q, ones_d;

   logic [LANES-1:0] step_bits;
   per_ptr_t         step_j;
   per_ptr_t         step_k;
   logic [5:0]       step_ones;
   logic [WIDTH-1:0] acc_next;
   logic             last_group;

   unper_step #(
      .LANES (LANES)
   ) u_step (
      .p      (p_q),
      .y      (y_q),
      .i_idx  (i_q),
      .j_ptr  (j_q),
      .k_ptr  (k_q),
      .bits   (step_bits),
      .j_next (step_j),
      .k_next (step_k),
      .ones   (step_ones)
   );

   // The group holding index 0 is the one whose top index is LANES-1.
   assign last_group = (i_q == 5'(LANES - 1));

   // Merge the current lane group into the accumulator.
   always_comb begin
      acc_next               = xacc_q;
      acc_next[i_q -: LANES] = step_bits;
   end

   // Next-state and datapath update for IDLE/RUN/DONE.
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      y_d     = y_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      xacc_d  = xacc_q;
      x_d     = x_q;
      ones_d  = ones_q;
      case (state_q)
         PER_IDLE: begin
            if (in_valid) begin
               p_d     = P;
               y_d     = Y;
               i_d     = 5'd31;
               j_d     = 6'd31;
               k_d     = 6'd0;
               xacc_d  = '0;
               ones_d  = 6'd0;
               state_d = PER_RUN;
            end else begin
               state_d = PER_IDLE;
            end
         end
         PER_RUN: begin
            xacc_d = acc_next;
            j_d    = step_j;
            k_d    = step_k;
            ones_d = ones_q + step_ones;
            i_d    = i_q - 5'(LANES);
            if (last_group) begin
               x_d     = acc_next;
               state_d = PER_DONE;
            end else begin
               state_d = PER_RUN;
            end
         end
         PER_DONE: begin
            if (out_ready) begin
               state_d = PER_IDLE;
`ifdef UNPER_SCRUB_EN
               x_d    = '0;
               ones_d = 6'd0;
               p_d    = '0;
               y_d    = '0;
               xacc_d = '0;
`endif
            end else begin
               state_d = PER_DONE;
            end
         end
         default: begin
            state_d = PER_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any work in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PER_IDLE;
         p_q     <= '0;
         y_q     <= '0;
         i_q     <= 5'd31;
         j_q     <= 6'd31;
         k_q     <= 6'd0;
         xacc_q  <= '0;
         x_q     <= '0;
         ones_q  <= 6'd0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         y_q     <= y_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         xacc_q  <= xacc_d;
         x_q     <= x_d;
         ones_q  <= ones_d;
      end
   end

   assign in_ready  = (state_q == PER_IDLE);
   assign out_valid = (state_q == PER_DONE);
   assign X         = x_q;
   assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_unper_32b.sv
// Randomized self-checking bench for unper_32b against a forward
// permutation model.
module tb_unper_32b;

   localparam int LANES  = 4;
   localparam int NGROUP = 32 / LANES;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] P;
   logic [31:0] Y;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] X;
   logic [5:0]  ones_cnt;

   int checks;
   int errors;

   unper_32b #(
      .WIDTH (32),
      .LANES (LANES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .P         (P),
      .Y         (Y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .X         (X),
      .ones_cnt  (ones_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Forward permutation: mask-1 bits packed from the MSB down, the rest
   // from the LSB up, both scanned from bit 31 downward.
   function automatic logic [31:0] fwd_perm(input logic [31:0] xw, input logic [31:0] yw);
      logic [31:0] pw;
      int hi;
      int lo;
      pw = 32'h0;
      hi = 31;
      lo = 0;
      for (int m = 31; m >= 0; m--) begin
         if (yw[m]) begin
            pw[hi] = xw[m];
            hi--;
         end else begin
            pw[lo] = xw[m];
            lo++;
         end
      end
      return pw;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one pair, wait for the result, check it, then hand it off.
   task automatic run_txn(input logic [31:0] pw, input logic [31:0] yw,
                          input logic [31:0] exp_x, input int stall);
      int cnt;
      cnt = 0;
      while (!in_ready && cnt < 200) begin
         tick();
         cnt++;
      end
      chk("accept_wait", 32'(in_ready), 32'd1);
      P        = pw;
      Y        = yw;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cnt      = 0;
      while (!out_valid && cnt < 200) begin
         tick();
         cnt++;
      end
      chk("latency", 32'(cnt), 32'(NGROUP));
      chk("x", X, exp_x);
      chk("ones_cnt", 32'(ones_cnt), 32'($countones(yw)));
      repeat (stall) tick();
      chk("x_hold", X, exp_x);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("in_ready_after", 32'(in_ready), 32'd1);
      chk("out_valid_after", 32'(out_valid), 32'd0);
`ifdef UNPER_SCRUB_EN
      chk("scrub_x", X, 32'h0);
      chk("scrub_ones", 32'(ones_cnt), 32'd0);
`else
      chk("x_keep", X, exp_x);
`endif
   endtask

   initial begin
      logic [31:0] xr;
      logic [31:0] yr;
      int sel;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      P         = 32'h0;
      Y         = 32'h0;
      repeat (2) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_x", X, 32'h0);
      chk("rst_ones", 32'(ones_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // Directed boundary vectors.
      run_txn(32'h12345678, 32'hFFFFFFFF, 32'h12345678, 0);
      run_txn(32'h00000001, 32'h00000000, 32'h80000000, 1);
      run_txn(32'h0000000F, 32'h00000000, 32'hF0000000, 0);
      run_txn(32'hAAAAAAAA, 32'hFFFF0000, 32'hAAAA5555, 2);

      // Hold in DONE with a stray in_valid pulse that must be ignored.
      P        = 32'hAAAAAAAA;
      Y        = 32'hFFFF0000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (NGROUP) tick();
      chk("hold_ov", 32'(out_valid), 32'd1);
      for (int c = 0; c < 10; c++) begin
         if (c == 4) begin
            P        = 32'h12345678;
            Y        = 32'h0F0F0F0F;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("hold_x", X, 32'hAAAA5555);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_ov_end", 32'(out_valid), 32'd1);
      chk("hold_ones", 32'(ones_cnt), 32'd16);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hold_release_ready", 32'(in_ready), 32'd1);
      repeat (NGROUP + 3) tick();
      chk("stray_ignored", 32'(out_valid), 32'd0);

      // Reset in the middle of RUN.
      P        = 32'hDEADBEEF;
      Y        = 32'h5A5A5A5A;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("midrst_ov", 32'(out_valid), 32'd0);
      chk("midrst_x", X, 32'h0);
      chk("midrst_ready", 32'(in_ready), 32'd1);
      chk("midrst_ones", 32'(ones_cnt), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("postrst_ov", 32'(out_valid), 32'd0);
      run_txn(fwd_perm(32'hCAFEF00D, 32'h5A5A5A5A), 32'h5A5A5A5A, 32'hCAFEF00D, 0);

      // Random round trips through the forward model.
      for (int n = 0; n < 2000; n++) begin
         xr  = $urandom;
         sel = int'($urandom_range(0, 9));
         if (sel == 0) begin
            yr = 32'hFFFFFFFF;
         end else if (sel == 1) begin
            yr = 32'h0;
         end else begin
            yr = $urandom;
         end
         run_txn(fwd_perm(xr, yr), yr, xr, int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
